ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Turns the raw PS/2 byte stream from PS2_Controller (received_data/received_data_en) into game actions.
//  Handles the F0 break prefix and the E0 extended prefix, and tracks which keys are held.
//  Emits one-cycle action pulses, plus auto-repeat for LEFT/RIGHT/DOWN.
//  Sits between PS2_Controller and FSM_screen/FSM_Home/FSM_Gameplay, replacing the level compares on last_data_received.
// PARAMETERS
//  REPEAT_DELAY   15_000_000  cycles from press to first auto-repeat pulse (300 ms at 50 MHz)
//  REPEAT_PERIOD   2_500_000  cycles between subsequent auto-repeat pulses (50 ms)
//  CNT_W                  24  repeat counter width; must hold max(REPEAT_DELAY,REPEAT_PERIOD)-1
// PORTS
//  CLOCK_50         in   1  system clock
//  Resetn           in   1  asynchronous active-low reset
//  ps2_key_data     in   8  byte from PS2_Controller
//  ps2_key_pressed  in   1  one-cycle strobe: ps2_key_data valid
//  flush            in   1  sync: clear held bits, repeat timer and prefix FSM (mode change)
//  act_pulse        out  9  one-cycle action pulses, bit map below
//  act_held         out  9  level: action key currently down
//  last_code        out  8  last non-prefix make byte (for HEX0/HEX1)
// BEHAVIOUR
//  Bit map / codes: 0 START 5A; 1 GAMEOVER 66; 2 EASY 16; 3 MEDIUM 1E; 4 HARD 26;
//    5 LEFT 1C | E0 6B; 6 RIGHT 23 | E0 74; 7 DOWN 1B | E0 72; 8 ROTATE 1D | E0 75.
//  Reset: act_pulse=0, act_held=0, last_code=00, FSM=S_IDLE, repeat timer idle.
//  Bytes are consumed only in cycles with ps2_key_pressed=1. All outputs are registered.
//    Latency: act_pulse is high for exactly 1 cycle, in the cycle after the strobe.
//  Prefix FSM, driven by each accepted byte:
//    S_IDLE: F0 -> S_F0; E0 -> S_E0; any other byte is a make -> stay in S_IDLE.
//    S_E0:   F0 -> S_E0F0; any other byte is an extended make -> S_IDLE.
//    S_F0:   byte is a normal break -> S_IDLE.
//    S_E0F0: byte is an extended break -> S_IDLE.
//  Make of a mapped key whose held bit is 0: set the held bit and pulse the action.
//  Make of a mapped key whose held bit is 1 (keyboard typematic): no pulse; the internal repeat timer governs.
//  Break: clear the held bit, no pulse. Normal and extended codes share one held bit; a break from either clears it.
//  Unmapped makes: update last_code only. Unmapped breaks: no effect.
//    E1/pause bytes get no special handling and are treated as unmapped.
//  last_code updates on every make (mapped or not); it is never updated on F0/E0 or on break bytes.
//  Auto-repeat applies to LEFT/RIGHT/DOWN only, with one shared timer that tracks the most recent repeatable press:
//    - New repeatable press: timer owner = that action; count loads REPEAT_DELAY-1.
//    - While the owner's held bit is 1: count decrements each cycle.
//        At 0 the owner's act_pulse fires and count reloads REPEAT_PERIOD-1.
//    - Owner released: timer goes idle, even if another repeatable key is still held. No handoff.
//  Same-cycle events:
//    - Break of owner coincides with timer terminal: break wins, no pulse.
//    - New repeatable make coincides with terminal: the new press pulses and takes ownership;
//      the old owner's repeat pulse is dropped.
//  flush=1: act_held=0, timer idle, FSM=S_IDLE, no pulse that cycle. flush takes priority over any strobe in the same cycle.
//  Reset mid-byte-sequence (e.g. after E0): FSM returns to S_IDLE. The stray break byte that follows is then read as a make:
//    if mapped it pulses. This is accepted behaviour.
// STRUCTURE
//  tetris_pkg holds: ACT_* bit indices, NUM_ACT=9, SC_* scancode constants, FSM state encodings.
//  Sub-module repeat_timer (CLOCK_50, Resetn, load_delay, stop, tick)
//    contains the CNT_W down-counter and the delay/period reload logic.
//  Top level: prefix FSM, make/break decode, held register, pulse register, last_code.
// TESTING
//  1. Strobe 1C, then F0 1C -> act_pulse[5] for 1 cycle after the first strobe;
//     act_held[5] = 1 until the cycle after the 1C break; last_code=1C.
//  2. Strobe E0 75, then E0 F0 75 -> a single act_pulse[8]; act_held[8] set, then cleared; no pulse on E0 or F0.
//  3. REPEAT_DELAY=20, REPEAT_PERIOD=5; press 23 and hold 40 cycles -> pulses at +1, +21, +26, +31, +36; release stops them.
//  4. Press 1B, then 1B repeated (typematic) 3x -> exactly one keyboard-driven pulse; timer pulses unaffected.
//  5. Hold 1C, press 23, release 23 while 1C is still held -> no further repeats of LEFT (no handoff).
//  6. Strobe E0, assert flush, then strobe 1D -> act_pulse[8] fires (FSM back in S_IDLE);
//     Resetn low mid-hold -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared action indices, scancodes, prefix FSM states and decode helpers.
// No latency (types, constants and pure functions only).
// No backpressure (no state).
package tetris_pkg;

  localparam int NUM_ACT = 9;

  // Action bit indices in act_pulse / act_held
  localparam logic [3:0] ACT_START    = 4'd0;
  localparam logic [3:0] ACT_GAMEOVER = 4'd1;
  localparam logic [3:0] ACT_EASY     = 4'd2;
  localparam logic [3:0] ACT_MEDIUM   = 4'd3;
  localparam logic [3:0] ACT_HARD     = 4'd4;
  localparam logic [3:0] ACT_LEFT     = 4'd5;
  localparam logic [3:0] ACT_RIGHT    = 4'd6;
  localparam logic [3:0] ACT_DOWN     = 4'd7;
  localparam logic [3:0] ACT_ROTATE   = 4'd8;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Normal (single-byte) scancodes
  localparam logic [7:0] SC_START    = 8'h5A;
  localparam logic [7:0] SC_GAMEOVER = 8'h66;
  localparam logic [7:0] SC_EASY     = 8'h16;
  localparam logic [7:0] SC_MEDIUM   = 8'h1E;
  localparam logic [7:0] SC_HARD     = 8'h26;
  localparam logic [7:0] SC_LEFT     = 8'h1C;
  localparam logic [7:0] SC_RIGHT    = 8'h23;
  localparam logic [7:0] SC_DOWN     = 8'h1B;
  localparam logic [7:0] SC_ROTATE   = 8'h1D;

  // Extended (E0-prefixed) scancodes: arrow keys
  localparam logic [7:0] SC_X_LEFT   = 8'h6B;
  localparam logic [7:0] SC_X_RIGHT  = 8'h74;
  localparam logic [7:0] SC_X_DOWN   = 8'h72;
  localparam logic [7:0] SC_X_ROTATE = 8'h75;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } decode_t;

  // Map a key byte (normal or extended set) to its action bit
  function automatic decode_t decode_code(input logic [7:0] code, input logic ext);
    decode_t d;
    d.hit = 1'b1;
    d.idx = ACT_START;
    if (ext) begin
      case (code)
        SC_X_LEFT:   d.idx = ACT_LEFT;
        SC_X_RIGHT:  d.idx = ACT_RIGHT;
        SC_X_DOWN:   d.idx = ACT_DOWN;
        SC_X_ROTATE: d.idx = ACT_ROTATE;
        default:     d.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_START:    d.idx = ACT_START;
        SC_GAMEOVER: d.idx = ACT_GAMEOVER;
        SC_EASY:     d.idx = ACT_EASY;
        SC_MEDIUM:   d.idx = ACT_MEDIUM;
        SC_HARD:     d.idx = ACT_HARD;
        SC_LEFT:     d.idx = ACT_LEFT;
        SC_RIGHT:    d.idx = ACT_RIGHT;
        SC_DOWN:     d.idx = ACT_DOWN;
        SC_ROTATE:   d.idx = ACT_ROTATE;
        default:     d.hit = 1'b0;
      endcase
    end
    return d;
  endfunction

  // Only the movement keys auto-repeat
  function automatic logic is_repeatable(input logic [3:0] idx);
    return (idx == ACT_LEFT) || (idx == ACT_RIGHT) || (idx == ACT_DOWN);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_repeat_timer.sv
// Shared auto-repeat down-counter: first tick after a delay, then periodic ticks.
// tick is combinational from the count register; it fires in the cycle count reaches 0.
// No backpressure; load_delay and stop both suppress a coincident tick (stop wins over load).
module repeat_timer
  import tetris_pkg::*;
#(
  parameter int REPEAT_DELAY  = 15_000_000,
  parameter int REPEAT_PERIOD = 2_500_000,
  parameter int CNT_W         = 24
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic load_delay,
  input  logic stop,
  output logic tick
);

  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

  logic             active;
  logic [CNT_W-1:0] count;

  // Terminal count, masked by a same-cycle release or a new owner taking over
  always_comb begin
    tick = active && (count == '0) && !load_delay && !stop;
  end

  // Counter: stop idles it, load arms the delay, terminal reloads the period
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      active <= 1'b0;
      count  <= '0;
    end else if (stop) begin
      active <= 1'b0;
      count  <= '0;
    end else if (load_delay) begin
      active <= 1'b1;
      count  <= DELAY_LD;
    end else if (tick) begin
      count  <= PERIOD_LD;
    end else if (active) begin
      count  <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode stream to game actions: F0/E0 prefix FSM, held-key tracking, auto-repeat.
// act_pulse/act_held/last_code are registered: visible the cycle after the accepted strobe.
// No backpressure: every ps2_key_pressed byte is consumed; flush overrides a coincident strobe.
module ps2_key_decoder
  import tetris_pkg::*;
#(
  parameter int REPEAT_DELAY  = 15_000_000,
  parameter int REPEAT_PERIOD = 2_500_000,
  parameter int CNT_W         = 24
) (
  input  logic               CLOCK_50,
  input  logic               Resetn,
  input  logic [7:0]         ps2_key_data,
  input  logic               ps2_key_pressed,
  input  logic               flush,
  output logic [NUM_ACT-1:0] act_pulse,
  output logic [NUM_ACT-1:0] act_held,
  output logic [7:0]         last_code
);

  state_t             state, state_nxt;
  logic [3:0]         owner, owner_nxt;
  logic [NUM_ACT-1:0] held_nxt;
  logic [NUM_ACT-1:0] pulse_nxt;
  logic [7:0]         last_nxt;
  logic               is_make;
  logic               is_break;
  logic               ext;
  decode_t            dec;
  logic               load_delay;
  logic               stop;
  logic               tick;

  repeat_timer #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .CNT_W         (CNT_W)
  ) u_repeat_timer (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .load_delay (load_delay),
    .stop       (stop),
    .tick       (tick)
  );

  // Prefix FSM, make/break decode, held/pulse/owner next-state and timer control
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    held_nxt   = act_held;
    pulse_nxt  = '0;
    last_nxt   = last_code;
    is_make    = 1'b0;
    is_break   = 1'b0;
    ext        = 1'b0;
    load_delay = 1'b0;
    stop       = 1'b0;
    dec        = '0;

    // tick is already masked when a new repeatable press or an owner break lands this cycle
    if (tick) begin
      pulse_nxt[owner] = 1'b1;
    end

    if (flush) begin
      state_nxt = S_IDLE;
      held_nxt  = '0;
      pulse_nxt = '0;
      stop      = 1'b1;
    end else if (ps2_key_pressed) begin
      case (state)
        S_IDLE: begin
          if (ps2_key_data == SC_BREAK)    state_nxt = S_F0;
          else if (ps2_key_data == SC_EXT) state_nxt = S_E0;
          else                             is_make   = 1'b1;
        end
        S_E0: begin
          if (ps2_key_data == SC_BREAK) begin
            state_nxt = S_E0F0;
          end else begin
            is_make   = 1'b1;
            ext       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_F0: begin
          is_break  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_E0F0: begin
          is_break  = 1'b1;
          ext       = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase

      dec = decode_code(ps2_key_data, ext);

      if (is_make) begin
        // A stray E0 after E0 walks the FSM but is never shown as a key code
        if ((ps2_key_data != SC_BREAK) && (ps2_key_data != SC_EXT)) begin
          last_nxt = ps2_key_data;
        end
        // Typematic re-makes of a held key are ignored; the timer owns repeats
        if (dec.hit && !act_held[dec.idx]) begin
          held_nxt[dec.idx]  = 1'b1;
          pulse_nxt[dec.idx] = 1'b1;
          if (is_repeatable(dec.idx)) begin
            load_delay = 1'b1;
            owner_nxt  = dec.idx;
          end
        end
      end else if (is_break && dec.hit) begin
        held_nxt[dec.idx] = 1'b0;
        // Releasing the owner idles the timer; other held movement keys do not inherit it
        if (dec.idx == owner) begin
          stop = 1'b1;
        end
      end
    end
  end

  // Registered state and outputs
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      owner     <= ACT_LEFT;
      act_held  <= '0;
      act_pulse <= '0;
      last_code <= 8'h00;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      act_held  <= held_nxt;
      act_pulse <= pulse_nxt;
      last_code <= last_nxt;
    end
  end

endmodule
